// File: rtl/gate_bist_checker.sv
// Built-in self-test checker for a 2-input logic gate.
// Drives the four {a,b} vectors in order and holds each one for SETTLE_CYCLES cycles.
// After the settle interval it samples dut_y and checks it against the truth table
// of the latched gate_sel.
// Optional feature macro: GATE_BIST_ACCUM_EN. When it is defined, err_count and
// fail_vec accumulate across runs and only rst clears them.
module gate_bist_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  input  logic             dut_y,
  output logic             dut_a,
  output logic             dut_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             invalid_sel,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  localparam logic [3:0]       SettleLast = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ErrMax     = {ERR_W{1'b1}};

  state_e           state_q;
  logic [2:0]       sel_q;
  logic [1:0]       vec_q;
  logic [3:0]       cnt_q;
  logic             run_err_q;
  logic             a_q, b_q, busy_q, done_q, pass_q, invalid_q;
  logic [ERR_W-1:0] err_q;
  logic [3:0]       fail_q;

  logic sel_valid;
  logic expected_y;
  logic mismatch;

  function automatic logic gate_eval(input logic [2:0] sel, input logic a, input logic b);
    case (sel)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return ~(a & b);
      3'b011:  return ~(a | b);
      3'b100:  return a ^ b;
      3'b101:  return ~(a ^ b);
      default: return 1'b0;
    endcase
  endfunction

  // Decode the expected gate output and the mismatch for the current vector.
  always_comb begin
    sel_valid  = (gate_sel[2:1] != 2'b11);
    expected_y = gate_eval(sel_q, vec_q[1], vec_q[0]);
    mismatch   = (dut_y != expected_y);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sel_q     <= 3'b000;
      vec_q     <= 2'd0;
      cnt_q     <= 4'd0;
      run_err_q <= 1'b0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      invalid_q <= 1'b0;
      err_q     <= '0;
      fail_q    <= 4'b0000;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            pass_q    <= 1'b0;
            run_err_q <= 1'b0;
            vec_q     <= 2'd0;
            cnt_q     <= 4'd0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
`ifdef GATE_BIST_ACCUM_EN
            // Accumulating build: results persist across runs until rst.
`else
            err_q     <= '0;
            fail_q    <= 4'b0000;
`endif
            if (sel_valid) begin
              sel_q     <= gate_sel;
              invalid_q <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= StSettle;
            end else begin
              // Skip the vectors entirely and report completion next cycle.
              invalid_q <= 1'b1;
              state_q   <= StDone;
            end
          end
        end
        StSettle: begin
          if (cnt_q == SettleLast) begin
            cnt_q   <= 4'd0;
            state_q <= StSample;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StSample: begin
          if (mismatch) begin
            run_err_q     <= 1'b1;
            fail_q[vec_q] <= 1'b1;
            if (err_q != ErrMax) begin
              err_q <= err_q + 1'b1;
            end
          end
          if (vec_q == 2'd3) begin
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            state_q <= StDone;
          end else begin
            vec_q   <= vec_q + 2'd1;
            {a_q, b_q} <= vec_q + 2'd1;
            state_q <= StSettle;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          pass_q  <= ~run_err_q & ~invalid_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dut_a       = a_q;
  assign dut_b       = b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign invalid_sel = invalid_q;
  assign err_count   = err_q;
  assign fail_vec    = fail_q;

endmodule

// File: doc/gate_bist_checker.md
Name: gate_bist_checker

Overview:
Synthesizable built-in self-test engine for a 2-input logic gate such as NAND_GATE. It drives the gate's A/B inputs through all four input combinations (00, 01, 10, 11) and samples the gate's Y output after a settle interval. Each sample is compared against the truth table selected by gate_sel, and the block reports pass/fail, an error count and a per-vector fail map. It is the hardware checking side of gate stimulus, placed beside the gate under test with start/done control from a host or top-level FSM.

Parameters:
SETTLE_CYCLES, 2, cycles the vector is held before sampling; legal range 1 to 15.
ERR_W, 3, width of err_count; minimum 1.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  run request; sampled only in IDLE
gate_sel  input  3  gate type: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110/111 invalid
dut_y  input  1  output of the gate under test
dut_a  output  1  A input to the gate under test (registered)
dut_b  output  1  B input to the gate under test (registered)
busy  output  1  high from the cycle after start is accepted until done
done  output  1  single-cycle completion pulse
pass  output  1  1 when the last run had zero mismatches and a valid gate_sel; held until the next accepted start
invalid_sel  output  1  last start used gate_sel 110/111; held until the next accepted start
err_count  output  ERR_W  mismatch count, saturating at 2^ERR_W-1
fail_vec  output  4  bit v set when vector v ({a,b}=v) mismatched

Behaviour:
- Reset (async, rst=1): state IDLE. dut_a, dut_b, busy, done, pass, invalid_sel, err_count and fail_vec are all 0. Settle counter and vector index are 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1, valid sel:
  - latch gate_sel
  - clear err_count, fail_vec, pass, invalid_sel
  - vector index v=0, dut_a/dut_b = 0/0
  - go to SETTLE, busy=1
- IDLE, start=1, invalid sel:
  - invalid_sel=1, pass=0
  - go to DONE; no vectors driven, dut_a/dut_b stay 0
- SETTLE: counter counts 0 to SETTLE_CYCLES-1, then go to SAMPLE. dut_a=v[1], dut_b=v[0] are held stable.
- SAMPLE (one cycle): at the closing edge, compare dut_y against expected(latched sel, v[1], v[0]).
  - On mismatch: err_count += 1 (saturating) and fail_vec[v] = 1.
  - If v<3: v += 1, drive the new vector, return to SETTLE with counter 0.
  - If v=3: go to DONE.
- DONE (one cycle): done=1, busy=0, pass = (no mismatch this run) and not invalid_sel. dut_a/dut_b return to 0. Next state IDLE.
- Latency: the edge accepting start is T0; done is high in cycle T0 + 4*(SETTLE_CYCLES+1) + 1. With SETTLE_CYCLES=2 that is cycle 13. For an invalid sel, done is high in cycle T0+1.
- start while busy or in DONE is ignored and not queued.
- gate_sel changes during a run have no effect; the latched value is used.
- Reset mid-run aborts immediately to reset values; no done pulse is issued.
- Results (pass, err_count, fail_vec, invalid_sel) remain stable in IDLE until the next accepted start.

Optional Feature:
GATE_BIST_ACCUM_EN
- Defined: an accepted start does not clear err_count or fail_vec. Counts accumulate across runs (saturating), and fail_vec bits OR together. Only rst clears them. pass still reflects only the most recent run.
- Undefined: err_count and fail_vec are cleared on every accepted start.

Test Plan:
- Correct NAND model (dut_y = ~(dut_a&dut_b)), gate_sel=010, SETTLE_CYCLES=2, start at T0 -> done pulse in cycle 13, pass=1, err_count=0, fail_vec=0000, dut_a/dut_b sequence 00,01,10,11 with each vector held 3 cycles.
- dut_y stuck at 1, gate_sel=000 (AND) -> done, pass=0, err_count=3, fail_vec=0111.
- gate_sel=111, start -> done in cycle T0+1, invalid_sel=1, pass=0, busy never high, dut_a/dut_b stay 0.
- Start pulsed again during vector 1 of a NAND run -> ignored; exactly one done, in cycle 13.
- rst asserted during SETTLE of vector 2 -> all outputs 0 immediately, no done pulse. A following start runs a clean 13-cycle pass.
- GATE_BIST_ACCUM_EN, ERR_W=3, dut_y stuck at 0, gate_sel=100 (XOR), four runs -> err_count 2, 4, 6, then 7 (saturated). fail_vec=0110 throughout, pass=0 each run.
